// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: ctrl bit positions,
// FSM states and default widths.
package mem_stage_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int CTRL_W_DEF = 17;
  localparam int DATA_W     = 32;
  localparam int REG_W      = 4;

  localparam int REG_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_TO_REG = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RWAIT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/read-valid bus; master is the pipeline stage,
// slave is the memory.
interface dmem_if #(
  parameter int ADDR_W = 16
);
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_out_reg.sv
// MEM/WB holding register: loads a new bundle, holds it until consumed.
module mem_wb_out_reg
  import mem_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_result,
  input  logic [REG_W-1:0]  ld_srcRegDir,
  input  logic [REG_W-1:0]  ld_Robj,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_result,
  output logic [REG_W-1:0]  o_srcRegDir,
  output logic [REG_W-1:0]  o_Robj
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid     <= 1'b0;
      o_ctrl      <= '0;
      o_result    <= '0;
      o_srcRegDir <= '0;
      o_Robj      <= '0;
    end else if (load) begin
      o_valid     <= 1'b1;
      o_ctrl      <= ld_ctrl;
      o_result    <= ld_result;
      o_srcRegDir <= ld_srcRegDir;
      o_Robj      <= ld_Robj;
    end else if (o_ready) begin
      o_valid     <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// EXE/MEM consumer: performs the data-memory access and feeds a registered
// MEM/WB bundle, stalling the pipeline while an access or result is pending.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_srcReg,
  input  logic [REG_W-1:0]  i_srcRegDir,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [REG_W-1:0]  i_Robj,
  dmem_if.master            dmem,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_result,
  output logic [REG_W-1:0]  o_srcRegDir,
  output logic [REG_W-1:0]  o_Robj
);

  mem_state_e        state, state_nx;
  logic [CTRL_W-1:0] ctrl_p0;
  logic [DATA_W-1:0] src_p0;
  logic [REG_W-1:0]  dir_p0;
  logic [DATA_W-1:0] alu_p0;
  logic [REG_W-1:0]  robj_p0;

  logic              acc, i_mem, load;
  logic [CTRL_W-1:0] ld_ctrl;
  logic [DATA_W-1:0] ld_result, rd_sel;
  logic [REG_W-1:0]  ld_dir, ld_robj;

  assign i_ready = (state == IDLE) && (!o_valid || o_ready);
  assign acc     = i_valid && i_ready;
  assign i_mem   = i_ctrl[MEM_READ] || i_ctrl[MEM_WRITE];
  assign rd_sel  = ctrl_p0[MEM_TO_REG] ? dmem.dmem_rdata : alu_p0;

  // Stage p0: accepted EXE/MEM fields, held for the duration of the access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ctrl_p0 <= '0;
      src_p0  <= '0;
      dir_p0  <= '0;
      alu_p0  <= '0;
      robj_p0 <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        ctrl_p0 <= i_ctrl;
        src_p0  <= i_srcReg;
        dir_p0  <= i_srcRegDir;
        alu_p0  <= i_alu;
        robj_p0 <= i_Robj;
      end
    end
  end

  // A grant arriving together with rvalid completes the read immediately;
  // a write takes priority over a read when both ctrl bits are set.
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    ld_ctrl   = ctrl_p0;
    ld_result = alu_p0;
    ld_dir    = dir_p0;
    ld_robj   = robj_p0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (i_mem) begin
            state_nx = REQ;
          end else begin
            load      = 1'b1;
            ld_ctrl   = i_ctrl;
            ld_result = i_alu;
            ld_dir    = i_srcRegDir;
            ld_robj   = i_Robj;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_gnt) begin
          if (ctrl_p0[MEM_WRITE]) begin
            load     = 1'b1;
            state_nx = IDLE;
          end else if (dmem.dmem_rvalid) begin
            load      = 1'b1;
            ld_result = rd_sel;
            state_nx  = IDLE;
          end else begin
            state_nx = RWAIT;
          end
        end
      end
      RWAIT: begin
        if (dmem.dmem_rvalid) begin
          load      = 1'b1;
          ld_result = rd_sel;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dmem.dmem_req   = (state == REQ);
  assign dmem.dmem_we    = (state == REQ) && ctrl_p0[MEM_WRITE];
  assign dmem.dmem_addr  = alu_p0[ADDR_W-1:0];
  assign dmem.dmem_wdata = src_p0;

  // Stage p1: MEM/WB output register
  mem_wb_out_reg #(
    .CTRL_W(CTRL_W)
  ) u_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .ld_ctrl     (ld_ctrl),
    .ld_result   (ld_result),
    .ld_srcRegDir(ld_dir),
    .ld_Robj     (ld_robj),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_ctrl      (o_ctrl),
    .o_result    (o_result),
    .o_srcRegDir (o_srcRegDir),
    .o_Robj      (o_Robj)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table driven through a small
// memory responder, plus hand-written reset, streaming and stall sequences.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [16:0] i_ctrl;
  logic [31:0] i_srcReg;
  logic [3:0]  i_srcRegDir;
  logic [31:0] i_alu;
  logic [3:0]  i_Robj;
  logic        o_valid;
  logic        o_ready;
  logic [16:0] o_ctrl;
  logic [31:0] o_result;
  logic [3:0]  o_srcRegDir;
  logic [3:0]  o_Robj;

  int checks = 0;
  int errors = 0;

  dmem_if #(.ADDR_W(16)) dmem ();

  mem_access_stage #(.ADDR_W(16), .CTRL_W(17)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_ctrl     (i_ctrl),
    .i_srcReg   (i_srcReg),
    .i_srcRegDir(i_srcRegDir),
    .i_alu      (i_alu),
    .i_Robj     (i_Robj),
    .dmem       (dmem),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_ctrl     (o_ctrl),
    .o_result   (o_result),
    .o_srcRegDir(o_srcRegDir),
    .o_Robj     (o_Robj)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] ctrl;
    logic [31:0] src;
    logic [3:0]  dir;
    logic [31:0] alu;
    logic [3:0]  robj;
    bit          mem;
    bit          we;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic [15:0] exp_addr;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[7];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [16:0] c, input logic [31:0] s, input logic [3:0] d,
                       input logic [31:0] a, input logic [3:0] r);
    i_valid     = 1'b1;
    i_ctrl      = c;
    i_srcReg    = s;
    i_srcRegDir = d;
    i_alu       = a;
    i_Robj      = r;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive(v.ctrl, v.src, v.dir, v.alu, v.robj);
    chk($sformatf("v%0d_in_ready", idx), {31'b0, i_ready}, 32'd1);
    step;
    i_valid = 1'b0;
    if (v.mem) begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        chk($sformatf("v%0d_req_c%0d", idx, k), {31'b0, dmem.dmem_req}, 32'd1);
        chk($sformatf("v%0d_we_c%0d", idx, k), {31'b0, dmem.dmem_we}, {31'b0, v.we});
        chk($sformatf("v%0d_addr_c%0d", idx, k), {16'b0, dmem.dmem_addr}, {16'b0, v.exp_addr});
        if (v.we) chk($sformatf("v%0d_wdata_c%0d", idx, k), dmem.dmem_wdata, v.src);
        chk($sformatf("v%0d_stall_c%0d", idx, k), {31'b0, i_ready}, 32'd0);
        chk($sformatf("v%0d_early_valid_c%0d", idx, k), {31'b0, o_valid}, 32'd0);
        if (k == v.gnt_dly) begin
          dmem.dmem_gnt = 1'b1;
          if (!v.we && v.rv_dly == 0) begin
            dmem.dmem_rvalid = 1'b1;
            dmem.dmem_rdata  = v.rdata;
          end
        end
        step;
      end
      dmem.dmem_gnt    = 1'b0;
      dmem.dmem_rvalid = 1'b0;
      if (!v.we && v.rv_dly > 0) begin
        for (int k = 1; k < v.rv_dly; k++) begin
          chk($sformatf("v%0d_rwait_req_%0d", idx, k), {31'b0, dmem.dmem_req}, 32'd0);
          chk($sformatf("v%0d_rwait_valid_%0d", idx, k), {31'b0, o_valid}, 32'd0);
          step;
        end
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = v.rdata;
        step;
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata  = 32'h0;
      end
    end
    chk($sformatf("v%0d_o_valid", idx), {31'b0, o_valid}, 32'd1);
    chk($sformatf("v%0d_o_result", idx), o_result, v.exp_res);
    chk($sformatf("v%0d_o_Robj", idx), {28'b0, o_Robj}, {28'b0, v.robj});
    chk($sformatf("v%0d_o_srcRegDir", idx), {28'b0, o_srcRegDir}, {28'b0, v.dir});
    chk($sformatf("v%0d_o_ctrl", idx), {15'b0, o_ctrl}, {15'b0, v.ctrl});
    step;
    chk($sformatf("v%0d_o_valid_clear", idx), {31'b0, o_valid}, 32'd0);
  endtask

  initial begin
    //            ctrl      src          dir   alu           robj mem we gnt rv rdata         addr      result
    vecs[0] = '{17'h00001, 32'h0,       4'h1, 32'h00000005, 4'h2, 0, 0, 0, 0, 32'h0,        16'h0,    32'h00000005};
    vecs[1] = '{17'h10000, 32'h0,       4'h3, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 32'h0,        16'h0,    32'hFFFFFFFF};
    vecs[2] = '{17'h00004, 32'hCAFEBABE,4'h4, 32'h00000010, 4'h5, 1, 1, 3, 0, 32'h0,        16'h0010, 32'h00000010};
    vecs[3] = '{17'h0000B, 32'h0,       4'h6, 32'h00000020, 4'h7, 1, 0, 1, 2, 32'h12345678, 16'h0020, 32'h12345678};
    vecs[4] = '{17'h0000B, 32'h0,       4'h8, 32'h00000024, 4'h9, 1, 0, 0, 0, 32'hA5A5A5A5, 16'h0024, 32'hA5A5A5A5};
    vecs[5] = '{17'h00003, 32'h0,       4'hA, 32'h00000044, 4'hB, 1, 0, 0, 1, 32'h0000BEEF, 16'h0044, 32'h00000044};
    vecs[6] = '{17'h00006, 32'h55AA55AA,4'hC, 32'h12340030, 4'hD, 1, 1, 0, 0, 32'h0,        16'h0030, 32'h12340030};

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ctrl = '0; i_srcReg = '0; i_srcRegDir = '0; i_alu = '0; i_Robj = '0;
    o_ready = 1'b1;
    dmem.dmem_gnt = 1'b0;
    dmem.dmem_rvalid = 1'b0;
    dmem.dmem_rdata = '0;

    repeat (3) step;
    chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_req", {31'b0, dmem.dmem_req}, 32'd0);
    chk("rst_we", {31'b0, dmem.dmem_we}, 32'd0);
    chk("rst_o_result", o_result, 32'd0);
    rst_n = 1'b1;
    step;
    chk("rst_i_ready", {31'b0, i_ready}, 32'd1);

    // stray gnt/rvalid while idle must be ignored
    dmem.dmem_gnt = 1'b1;
    dmem.dmem_rvalid = 1'b1;
    dmem.dmem_rdata = 32'hBAD0BAD0;
    step;
    dmem.dmem_gnt = 1'b0;
    dmem.dmem_rvalid = 1'b0;
    step;
    chk("idle_stray_valid", {31'b0, o_valid}, 32'd0);
    chk("idle_stray_ready", {31'b0, i_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // three back-to-back ALU bundles at full throughput
    drive(17'h00001, 32'h0, 4'h1, 32'h00000005, 4'h1);
    chk("b2b_ready0", {31'b0, i_ready}, 32'd1);
    step;
    chk("b2b_valid0", {31'b0, o_valid}, 32'd1);
    chk("b2b_res0", o_result, 32'h5);
    chk("b2b_ready1", {31'b0, i_ready}, 32'd1);
    drive(17'h00001, 32'h0, 4'h1, 32'h00000006, 4'h2);
    step;
    chk("b2b_valid1", {31'b0, o_valid}, 32'd1);
    chk("b2b_res1", o_result, 32'h6);
    chk("b2b_ready2", {31'b0, i_ready}, 32'd1);
    drive(17'h00001, 32'h0, 4'h1, 32'h00000007, 4'h3);
    step;
    i_valid = 1'b0;
    chk("b2b_valid2", {31'b0, o_valid}, 32'd1);
    chk("b2b_res2", o_result, 32'h7);
    chk("b2b_robj2", {28'b0, o_Robj}, 32'h3);
    step;
    chk("b2b_drain", {31'b0, o_valid}, 32'd0);

    // back-pressure: result held for 5 cycles, competing bundle refused
    o_ready = 1'b0;
    drive(17'h00001, 32'h0, 4'h2, 32'h00000099, 4'h3);
    step;
    drive(17'h00001, 32'h0, 4'h4, 32'h000000AB, 4'h6);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), {31'b0, o_valid}, 32'd1);
      chk($sformatf("bp_res_%0d", k), o_result, 32'h99);
      chk($sformatf("bp_robj_%0d", k), {28'b0, o_Robj}, 32'h3);
      chk($sformatf("bp_dir_%0d", k), {28'b0, o_srcRegDir}, 32'h2);
      chk($sformatf("bp_stall_%0d", k), {31'b0, i_ready}, 32'd0);
      step;
    end
    o_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, i_ready}, 32'd1);
    step;
    i_valid = 1'b0;
    chk("bp_new_valid", {31'b0, o_valid}, 32'd1);
    chk("bp_new_res", o_result, 32'hAB);
    chk("bp_new_robj", {28'b0, o_Robj}, 32'h6);
    step;
    chk("bp_drain", {31'b0, o_valid}, 32'd0);

    // reset after grant, before read data returns
    drive(17'h0000B, 32'h0, 4'h1, 32'h00000040, 4'h2);
    step;
    i_valid = 1'b0;
    chk("rmid_req", {31'b0, dmem.dmem_req}, 32'd1);
    dmem.dmem_gnt = 1'b1;
    step;
    dmem.dmem_gnt = 1'b0;
    chk("rmid_stall", {31'b0, i_ready}, 32'd0);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    dmem.dmem_rvalid = 1'b1;
    dmem.dmem_rdata = 32'h0000DEAD;
    step;
    dmem.dmem_rvalid = 1'b0;
    chk("rmid_valid", {31'b0, o_valid}, 32'd0);
    chk("rmid_req_off", {31'b0, dmem.dmem_req}, 32'd0);
    chk("rmid_ready", {31'b0, i_ready}, 32'd1);
    step;
    chk("rmid_valid_late", {31'b0, o_valid}, 32'd0);
    chk("rmid_result", o_result, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
